// File: rtl/bcd_scan_display_pkg.sv
// Shared constants for the multiplexed BCD display.
// Holds the seven-segment codes (gfedcba, active-high), the digit-index
// width and a helper that flags non-BCD nibbles in a packed 4-digit word.
package bcd_scan_display_pkg;

  localparam int unsigned NumDigits = 4;
  localparam int unsigned IdxW      = 2;

  typedef logic [IdxW-1:0] idx_t;

  localparam logic [6:0] Seg0     = 7'h3F;
  localparam logic [6:0] Seg1     = 7'h06;
  localparam logic [6:0] Seg2     = 7'h5B;
  localparam logic [6:0] Seg3     = 7'h4F;
  localparam logic [6:0] Seg4     = 7'h66;
  localparam logic [6:0] Seg5     = 7'h6D;
  localparam logic [6:0] Seg6     = 7'h7D;
  localparam logic [6:0] Seg7     = 7'h07;
  localparam logic [6:0] Seg8     = 7'h7F;
  localparam logic [6:0] Seg9     = 7'h6F;
  localparam logic [6:0] SegDash  = 7'h40;
  localparam logic [6:0] SegBlank = 7'h00;

  // True when any of the four nibbles lies outside 0..9.
  function automatic logic has_invalid(input logic [15:0] word);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < NumDigits; i++) begin
      if (word[i*4 +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

endpackage

// File: rtl/bcd_scan_display_bcd_to_7seg.sv
// Combinational BCD to seven-segment decoder.
//   digit_i : 4-bit BCD nibble
//   seg_o   : segments gfedcba, active-high; non-BCD input shows a dash
module bcd_to_7seg
  import bcd_scan_display_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SegDash;
    case (digit_i)
      4'd0:    seg_o = Seg0;
      4'd1:    seg_o = Seg1;
      4'd2:    seg_o = Seg2;
      4'd3:    seg_o = Seg3;
      4'd4:    seg_o = Seg4;
      4'd5:    seg_o = Seg5;
      4'd6:    seg_o = Seg6;
      4'd7:    seg_o = Seg7;
      4'd8:    seg_o = Seg8;
      4'd9:    seg_o = Seg9;
      default: seg_o = SegDash;
    endcase
  end

endmodule

// File: rtl/bcd_scan_display.sv
// Four-digit multiplexed seven-segment driver with tear-free frame update.
//   clk, rst_n : clock and synchronous active-low reset
//   bcd_in     : four BCD digits, [15:12] most significant
//   load       : capture strobe for bcd_in
//   seg        : registered segments gfedcba, active-high
//   an         : registered one-hot digit enable
//   frame_done : high in the last cycle of the digit3 window
//   err        : sticky, set when a non-BCD nibble is captured
module bcd_scan_display
  import bcd_scan_display_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 4,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] bcd_in,
  input  logic        load,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        frame_done,
  output logic        err
);

  localparam logic [15:0] PrescMax = 16'(SCAN_DIV - 1);

  logic [15:0] presc_q, presc_d;
  idx_t        idx_q, idx_d;
  logic [15:0] pend_q, pend_d;
  logic [15:0] frame_q, frame_d;
  logic        err_q, err_d;
  logic [6:0]  seg_q, seg_d;
  logic [3:0]  an_q, an_d;
  logic        fd_q, fd_d;

  logic        wrap;
  logic        boundary;
  logic [3:0]  digit_nxt;
  logic [6:0]  seg_dec;
  logic [3:0]  lz;

  bcd_to_7seg u_dec (
    .digit_i (digit_nxt),
    .seg_o   (seg_dec)
  );

  // Outputs are registered from next-state values so an and seg always
  // describe the digit index held in the same cycle.
  always_comb begin
    wrap     = (presc_q == PrescMax);
    boundary = wrap && (idx_q == idx_t'(NumDigits - 1));
    presc_d  = wrap ? 16'd0 : presc_q + 16'd1;
    idx_d    = wrap ? idx_q + idx_t'(1) : idx_q;
    pend_d   = load ? bcd_in : pend_q;
    // A load on the boundary bypasses pending so it shows immediately.
    frame_d  = boundary ? pend_d : frame_q;
    err_d    = err_q | (load & has_invalid(bcd_in));

    digit_nxt = frame_d[{idx_d, 2'b00} +: 4];

    // lz[k]: digit k and everything above it are zero; digit0 never blanks.
    lz    = 4'b0000;
    lz[3] = (frame_d[15:12] == 4'd0);
    lz[2] = lz[3] && (frame_d[11:8] == 4'd0);
    lz[1] = lz[2] && (frame_d[7:4] == 4'd0);

    seg_d = (BLANK_LZ && lz[idx_d]) ? SegBlank : seg_dec;
    an_d  = 4'b0001 << idx_d;
    fd_d  = (idx_d == idx_t'(NumDigits - 1)) && (presc_d == PrescMax);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q <= 16'd0;
      idx_q   <= '0;
      pend_q  <= 16'd0;
      frame_q <= 16'd0;
      err_q   <= 1'b0;
      seg_q   <= Seg0;
      an_q    <= 4'b0001;
      fd_q    <= 1'b0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      frame_q <= frame_d;
      err_q   <= err_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      fd_q    <= fd_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = fd_q;
  assign err        = err_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
module tb_bcd_scan_display;

  logic        clk;
  logic        rst_n;
  logic [15:0] bcd_in;
  logic        load;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_done;
  logic        err;

  int total;
  int bad;

  bcd_scan_display #(
    .SCAN_DIV (4),
    .BLANK_LZ (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bcd_in     (bcd_in),
    .load       (load),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bcd;
    logic [6:0]  s0, s1, s2, s3;
    logic        err;
  } vec_t;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       fd;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[8];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
    end
  endtask

  // Expected 16-cycle frame, digit0 window first.
  task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3);
    logic [6:0] s[4];
    exp_t e;
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < 4; c++) begin
        e.an  = 4'b0001 << d;
        e.seg = s[d];
        e.fd  = (d == 3) && (c == 3);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic check_one();
    exp_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL scoreboard: queue empty at %0t", $time);
    end else begin
      total--;
      e = exp_q.pop_front();
      chk("an", 16'(an), 16'(e.an));
      chk("seg", 16'(seg), 16'(e.seg));
      chk("frame_done", 16'(frame_done), 16'(e.fd));
    end
  endtask

  // Returns at a negedge during which frame_done is high.
  task automatic wait_frame_done();
    int i;
    for (i = 0; i < 100; i++) begin
      if (frame_done === 1'b1) break;
      @(negedge clk);
    end
    if (i == 100) begin
      total++;
      bad++;
      $display("FAIL frame_done_timeout: got none want pulse within 100 cycles");
    end
  endtask

  // Load on the frame boundary; the value is shown in the very next frame.
  task automatic apply_vec(input vec_t v);
    wait_frame_done();
    bcd_in = v.bcd;
    load   = 1'b1;
    push_frame(v.s0, v.s1, v.s2, v.s3);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 0) begin
        load = 1'b0;
        chk("err", 16'(err), 16'(v.err));
      end
      check_one();
    end
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    rst_n  = 1'b0;
    load   = 1'b0;
    bcd_in = 16'h0000;

    vecs[0] = '{16'h1234, 7'h66, 7'h4F, 7'h5B, 7'h06, 1'b0};
    vecs[1] = '{16'h0090, 7'h3F, 7'h6F, 7'h00, 7'h00, 1'b0};
    vecs[2] = '{16'h0000, 7'h3F, 7'h00, 7'h00, 7'h00, 1'b0};
    vecs[3] = '{16'h8009, 7'h6F, 7'h3F, 7'h3F, 7'h7F, 1'b0};
    vecs[4] = '{16'h00A5, 7'h6D, 7'h40, 7'h00, 7'h00, 1'b1};
    vecs[5] = '{16'h0001, 7'h06, 7'h00, 7'h00, 7'h00, 1'b1};
    vecs[6] = '{16'h0F00, 7'h3F, 7'h3F, 7'h40, 7'h00, 1'b1};
    vecs[7] = '{16'h1234, 7'h66, 7'h4F, 7'h5B, 7'h06, 1'b1};

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    chk("rst_an", 16'(an), 16'h0001);
    chk("rst_seg", 16'(seg), 16'h003F);
    chk("rst_err", 16'(err), 16'h0000);
    chk("rst_fd", 16'(frame_done), 16'h0000);
    rst_n = 1'b1;

    foreach (vecs[i]) apply_vec(vecs[i]);

    // Tear-free: 5678 loaded during digit1 of a 1234 frame.
    wait_frame_done();
    push_frame(7'h66, 7'h4F, 7'h5B, 7'h06);
    push_frame(7'h7F, 7'h07, 7'h7D, 7'h6D);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      check_one();
      if (i == 4) begin
        bcd_in = 16'h5678;
        load   = 1'b1;
      end
      if (i == 5) load = 1'b0;
    end

    // Reset during the digit2 window; a load during reset must be ignored.
    wait_frame_done();
    for (int i = 0; i < 9; i++) @(negedge clk);
    chk("mid_an_before", 16'(an), 16'h0004);
    rst_n  = 1'b0;
    load   = 1'b1;
    bcd_in = 16'h9999;
    @(negedge clk);
    chk("mid_rst_an", 16'(an), 16'h0001);
    chk("mid_rst_seg", 16'(seg), 16'h003F);
    chk("mid_rst_err", 16'(err), 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    load  = 1'b0;
    push_frame(7'h3F, 7'h00, 7'h00, 7'h00);
    check_one();
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      check_one();
    end
    chk("mid_rst_err_after", 16'(err), 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bcd_scan_display.md
BCD_SCAN_DISPLAY -- requirements
Module: bcd_scan_display

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 4, clock cycles each digit is shown; legal range 2..65535.
REQ-002 SHALL have parameter BLANK_LZ, default 1, enable for leading-zero blanking.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port bcd_in  input  16  four BCD digits; [15:12]=digit3 (most significant) .. [3:0]=digit0, fed by cascaded decade counters.
REQ-006 SHALL have port load  input  1  capture strobe for bcd_in.
REQ-007 SHALL have port seg  output  7  segments, active-high; seg[0]=a .. seg[6]=g.
REQ-008 SHALL have port an  output  4  one-hot digit enable, active-high; an[i] selects digit i.
REQ-009 SHALL have port frame_done  output  1  one-cycle pulse at the end of each full scan.
REQ-010 SHALL have port err  output  1  sticky flag for a captured non-BCD nibble.

Function
REQ-011 SHALL keep a prescaler counting 0..SCAN_DIV-1 that wraps to 0.
REQ-012 SHALL advance digit index 0->1->2->3->0 on every prescaler wrap.
REQ-013 SHALL drive an and seg from registers, both reflecting the same digit index in the same cycle.
REQ-014 SHALL capture bcd_in into a pending register on any cycle where load=1; last load wins.
REQ-015 SHALL copy pending to the frame register only at a frame boundary (index 3 and prescaler SCAN_DIV-1), so a frame is never torn.
REQ-016 SHALL, when load coincides with a frame boundary, copy bcd_in directly into the frame register; the new value is shown from the next digit-0 window.
REQ-017 SHALL decode digits 0-9 (gfedcba) as 3F,06,5B,4F,66,6D,7D,07,7F,6F hex.
REQ-018 SHALL display nibbles 10-15 as "-" (seg=40 hex) and set err at capture; err stays set until reset.
REQ-019 SHALL, with BLANK_LZ=1, drive seg=00 for digit k (k=3,2,1) when it and all more-significant digits are zero.
REQ-020 SHALL never blank digit0.
REQ-021 SHALL count an invalid nibble as non-zero for blanking.
REQ-022 SHALL keep an asserted for a blanked digit.
REQ-023 SHALL pulse frame_done high for exactly the last cycle of the digit3 window, once every 4*SCAN_DIV cycles.

Reset
REQ-024 SHALL, while rst_n=0 at a rising edge, clear prescaler, digit index, pending and frame registers, and err.
REQ-025 SHALL, on that reset, set an=0001, seg=3F (digit 0) and frame_done=0.
REQ-026 SHALL ignore load while rst_n=0.
REQ-027 SHALL, when reset is asserted mid-scan, resume scanning at digit 0 with a full prescaler window after release.

Structure
REQ-028 SHALL place the segment code constants (0-9 codes, dash 40, blank 00) and the digit-index width in a shared package.
REQ-029 SHALL use one combinational sub-module, bcd_to_7seg: 4-bit in, 7-bit out, dash for invalid input.

Verification (SCAN_DIV=4, BLANK_LZ=1)
REQ-030 SHALL cover reset: rst_n=0 for 2 cycles -> an=0001, seg=3F, err=0, frame_done=0.
REQ-031 SHALL cover a normal scan: load 1234 hex -> from next frame, seg=66/4F/5B/06 with an=0001/0010/0100/1000, 4 cycles each; frame_done every 16 cycles.
REQ-032 SHALL cover leading-zero blanking: load 0090 -> digit3,2 seg=00, digit1 seg=6F, digit0 seg=3F; load 0000 -> only digit0 shows 3F.
REQ-033 SHALL cover invalid input: load 00A5 -> digit1 seg=40, digit0 seg=6D, err=1; err remains 1 after loading 0001, clears only on reset.
REQ-034 SHALL cover tear-free update: load 5678 while digit1 of 1234 is shown -> digits 2,3 still show 5B,06; next frame shows 7F,07,7D,6D.
REQ-035 SHALL cover reset mid-scan: rst_n=0 during the digit2 window -> next cycle an=0001, seg=3F; the frame register reads 0000.
